// File: rtl/can_crc_ctrl.sv
// ---------------------------------------------------------------------------
// can_crc_ctrl
// Sequencer for the 64-bit parallel CAN CRC-15 engine (poly 0x4599).
// Destuffed frame bits arrive one per cycle, are packed into 64-bit words
// (first bit at [63]) and handed to the external engine. Bits left over after
// the last full word are folded in by an internal bit-serial LFSR, after which
// the final CRC is presented on crc_out with crc_valid.
//
// Optional feature macro: CAN_CRC_SELFCHECK_EN
//   Adds a shadow bit-serial CRC over every accepted bit and the sticky
//   err_selfcheck output, set in DONE when the shadow disagrees with crc_out.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   start             begin a new frame (priority over everything else)
//   bit_valid/bit_in  frame bit stream, transmission order
//   bit_last          marks the final CRC-covered bit
//   bit_ready         bits are accepted this cycle (COLLECT only)
//   busy              frame in progress, start until crc_valid
//   crc_valid/crc_out final CRC, held until next start
//   err_overrun       sticky: bit_valid seen while bit_ready=0
//   eng_clr           engine synchronous clear
//   eng_en/eng_data   engine update strobe and 64-bit data word
//   eng_crc           engine register, valid the cycle after eng_en
//   err_selfcheck     sticky shadow-CRC mismatch (macro builds only)
// ---------------------------------------------------------------------------
module can_crc_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        bit_valid,
   input  logic        bit_in,
   input  logic        bit_last,
   output logic        bit_ready,
   output logic        busy,
   output logic        crc_valid,
   output logic [14:0] crc_out,
   output logic        err_overrun,
   output logic        eng_clr,
   output logic        eng_en,
   output logic [63:0] eng_data,
   input  logic [14:0] eng_crc
`ifdef CAN_CRC_SELFCHECK_EN
   ,
   output logic        err_selfcheck
`endif
);

   typedef enum logic [2:0] {IDLE, COLLECT, WAIT, TAIL, DONE} state_t;

   state_t      state, state_nxt;
   logic [5:0]  count;
   logic [63:0] sreg;
   logic [14:0] lfsr;
   logic        word_seen;
   // Set when the final bit also completed a word: that word's engine result
   // only becomes visible on the first DONE cycle, so it is taken from eng_crc
   // there instead of from the WAIT load.
   logic        eng_late;
   logic [63:0] word_nxt;

   function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
      logic fb;
      fb = b ^ crc[14];
      return {crc[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
   endfunction

   assign word_nxt = {sreg[62:0], bit_in};

   always_comb begin
      state_nxt = state;
      bit_ready = 1'b0;
      busy      = 1'b0;
      crc_valid = 1'b0;
      crc_out   = 15'h0000;
      case (state)
         IDLE: ;
         COLLECT: begin
            bit_ready = 1'b1;
            busy      = 1'b1;
            if (bit_valid && bit_last)
               state_nxt = WAIT;
         end
         WAIT: begin
            busy      = 1'b1;
            state_nxt = (count == 6'd0) ? DONE : TAIL;
         end
         TAIL: begin
            busy = 1'b1;
            if (count == 6'd1)
               state_nxt = DONE;
         end
         DONE: begin
            crc_valid = 1'b1;
            crc_out   = eng_late ? eng_crc : lfsr;
         end
         default: state_nxt = IDLE;
      endcase
      if (start)
         state_nxt = COLLECT;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         count       <= 6'd0;
         sreg        <= 64'd0;
         lfsr        <= 15'h0000;
         word_seen   <= 1'b0;
         eng_late    <= 1'b0;
         err_overrun <= 1'b0;
         eng_clr     <= 1'b0;
         eng_en      <= 1'b0;
         eng_data    <= 64'd0;
      end else begin
         state   <= state_nxt;
         eng_clr <= start;
         eng_en  <= 1'b0;
         if (start) begin
            count       <= 6'd0;
            sreg        <= 64'd0;
            lfsr        <= 15'h0000;
            word_seen   <= 1'b0;
            eng_late    <= 1'b0;
            err_overrun <= 1'b0;
         end else begin
            if (bit_valid && !bit_ready)
               err_overrun <= 1'b1;
            case (state)
               COLLECT: begin
                  if (bit_valid) begin
                     sreg  <= word_nxt;
                     count <= count + 6'd1;
                     // 64th bit of a word: issue it; count wraps to 0 by itself
                     if (count == 6'd63) begin
                        eng_data  <= word_nxt;
                        eng_en    <= 1'b1;
                        word_seen <= 1'b1;
                        eng_late  <= bit_last;
                     end
                  end
               end
               WAIT: lfsr <= word_seen ? eng_crc : 15'h0000;
               TAIL: begin
                  // remaining bits sit in sreg[count-1:0], oldest at the top
                  lfsr  <= crc15_step(lfsr, sreg[count - 6'd1]);
                  count <= count - 6'd1;
               end
               DONE: begin
                  if (eng_late) begin
                     lfsr     <= eng_crc;
                     eng_late <= 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef CAN_CRC_SELFCHECK_EN
   logic [14:0] shadow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow        <= 15'h0000;
         err_selfcheck <= 1'b0;
      end else if (start) begin
         shadow        <= 15'h0000;
         err_selfcheck <= 1'b0;
      end else begin
         if (state == COLLECT && bit_valid)
            shadow <= crc15_step(shadow, bit_in);
         if (state == DONE && crc_out != shadow)
            err_selfcheck <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_can_crc_ctrl.sv
// Self-checking bench for can_crc_ctrl with a behavioural 64-bit CRC engine.
module tb_can_crc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        bit_valid;
   logic        bit_in;
   logic        bit_last;
   logic        bit_ready;
   logic        busy;
   logic        crc_valid;
   logic [14:0] crc_out;
   logic        err_overrun;
   logic        eng_clr;
   logic        eng_en;
   logic [63:0] eng_data;
   logic [14:0] eng_crc;
`ifdef CAN_CRC_SELFCHECK_EN
   logic        err_selfcheck;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int en_total = 0;

   can_crc_ctrl dut (
      .clk(clk), .rst(rst), .start(start),
      .bit_valid(bit_valid), .bit_in(bit_in), .bit_last(bit_last),
      .bit_ready(bit_ready), .busy(busy), .crc_valid(crc_valid),
      .crc_out(crc_out), .err_overrun(err_overrun),
      .eng_clr(eng_clr), .eng_en(eng_en), .eng_data(eng_data),
      .eng_crc(eng_crc)
`ifdef CAN_CRC_SELFCHECK_EN
      , .err_selfcheck(err_selfcheck)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [14:0] crc_bit(input logic [14:0] c, input logic b);
      logic x;
      x = b ^ c[14];
      return {c[13:0], 1'b0} ^ (x ? 15'h4599 : 15'h0000);
   endfunction

   function automatic logic [14:0] crc_word(input logic [14:0] c, input logic [63:0] w);
      logic [14:0] r;
      r = c;
      for (int i = 63; i >= 0; i--) r = crc_bit(r, w[i]);
      return r;
   endfunction

   function automatic logic [14:0] ref_crc(input int len, input logic [127:0] bits);
      logic [14:0] r;
      r = 15'h0000;
      for (int i = 0; i < len; i++) r = crc_bit(r, bits[i]);
      return r;
   endfunction

   // Behavioural parallel engine
   logic [14:0] eng_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          eng_q <= 15'h0000;
      else if (eng_clr) eng_q <= 15'h0000;
      else if (eng_en)  eng_q <= crc_word(eng_q, eng_data);
   end
   assign eng_crc = eng_q;

   always @(posedge clk) if (eng_en) en_total <= en_total + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Starts a frame, feeds len bits back-to-back, optionally pokes one bit in
   // WAIT, then waits (bounded) for crc_valid.
   task automatic run_frame(input int len, input logic [127:0] bits, input bit ovr,
                            output logic [14:0] crc, output int lat,
                            output int nen, output int stalls);
      int en0;
      stalls = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      en0 = en_total;
      for (int i = 0; i < len; i++) begin
         bit_valid = 1'b1;
         bit_in    = bits[i];
         bit_last  = (i == len - 1);
         if (!bit_ready) stalls++;
         @(negedge clk);
      end
      bit_valid = 1'b0; bit_last = 1'b0; bit_in = 1'b0;
      lat = 1;
      if (ovr) begin
         bit_valid = 1'b1; bit_in = 1'b1;
         @(negedge clk);
         bit_valid = 1'b0; bit_in = 1'b0;
         lat = 2;
      end
      while (!crc_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      crc = crc_out;
      nen = en_total - en0;
   endtask

   typedef struct {
      int           len;
      logic [127:0] bits;
      logic [14:0]  exp;
      bit           use_ref;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [14:0] crc, crc_hold;
      logic [127:0] rb;
      int lat, nen, stalls, en0;

      vecs[0] = '{1,   128'h1, 15'h4599, 1'b0};
      vecs[1] = '{2,   128'h1, 15'h4EAB, 1'b0};
      vecs[2] = '{64,  128'h0, 15'h0000, 1'b0};
      vecs[3] = '{65,  {63'h0, 1'b1, 64'h0}, 15'h4599, 1'b0};
      vecs[4] = '{19,  {$urandom, $urandom, $urandom, $urandom}, 15'h0, 1'b1};
      vecs[5] = '{63,  {$urandom, $urandom, $urandom, $urandom}, 15'h0, 1'b1};
      vecs[6] = '{64,  {$urandom, $urandom, $urandom, $urandom}, 15'h0, 1'b1};
      vecs[7] = '{127, {128{1'b1}}, 15'h0, 1'b1};
      vecs[8] = '{$urandom_range(66, 127), {$urandom, $urandom, $urandom, $urandom}, 15'h0, 1'b1};
      vecs[9] = '{$urandom_range(19, 127), {$urandom, $urandom, $urandom, $urandom}, 15'h0, 1'b1};

      rst = 1'b1; start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; bit_last = 1'b0;
      #12;
      check("rst_bit_ready", 64'(bit_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_crc_valid", 64'(crc_valid), 64'd0);
      check("rst_crc_out", 64'(crc_out), 64'd0);
      check("rst_err_overrun", 64'(err_overrun), 64'd0);
      check("rst_eng_en", 64'(eng_en), 64'd0);
      check("rst_eng_clr", 64'(eng_clr), 64'd0);
      check("rst_eng_data", eng_data, 64'd0);
      @(negedge clk); rst = 1'b0;

      // start handshake: eng_clr pulse, busy/bit_ready the cycle after start
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("start_eng_clr", 64'(eng_clr), 64'd1);
      check("start_busy", 64'(busy), 64'd1);
      check("start_bit_ready", 64'(bit_ready), 64'd1);
      @(negedge clk);
      check("start_eng_clr_drop", 64'(eng_clr), 64'd0);

      foreach (vecs[k]) begin
         logic [14:0] exp;
         exp = vecs[k].use_ref ? ref_crc(vecs[k].len, vecs[k].bits) : vecs[k].exp;
         run_frame(vecs[k].len, vecs[k].bits, 1'b0, crc, lat, nen, stalls);
         check($sformatf("v%0d_crc", k), 64'(crc), 64'(exp));
         check($sformatf("v%0d_latency", k), 64'(lat), 64'(2 + vecs[k].len % 64));
         check($sformatf("v%0d_eng_en_count", k), 64'(nen), 64'(vecs[k].len / 64));
         check($sformatf("v%0d_stalls", k), 64'(stalls), 64'd0);
         check($sformatf("v%0d_busy_done", k), 64'(busy), 64'd0);
`ifdef CAN_CRC_SELFCHECK_EN
         check($sformatf("v%0d_selfcheck", k), 64'(err_selfcheck), 64'd0);
`endif
      end

      // overrun during WAIT: bit dropped, CRC and latency unchanged
      run_frame(3, 128'h5, 1'b1, crc, lat, nen, stalls);
      check("ovr_wait_flag", 64'(err_overrun), 64'd1);
      check("ovr_wait_crc", 64'(crc), 64'(ref_crc(3, 128'h5)));
      check("ovr_wait_latency", 64'(lat), 64'd5);

      // overrun in DONE: flag sets, result held; next start clears flag
      rb = {$urandom, $urandom, $urandom, $urandom};
      run_frame(30, rb, 1'b0, crc, lat, nen, stalls);
      check("done_no_ovr", 64'(err_overrun), 64'd0);
      crc_hold = crc;
      bit_valid = 1'b1; bit_in = 1'b1;
      @(negedge clk); bit_valid = 1'b0; bit_in = 1'b0;
      @(negedge clk);
      check("ovr_done_flag", 64'(err_overrun), 64'd1);
      check("ovr_done_valid", 64'(crc_valid), 64'd1);
      check("ovr_done_crc", 64'(crc_out), 64'(crc_hold));
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("start_clears_ovr", 64'(err_overrun), 64'd0);
      check("start_clears_valid", 64'(crc_valid), 64'd0);

      // abort mid-frame, then a clean frame must be correct
      for (int a = 0; a < 2; a++) begin
         int nab;
         nab = (a == 0) ? 40 : 100;
         @(negedge clk); start = 1'b1;
         @(negedge clk); start = 1'b0;
         en0 = en_total;
         for (int i = 0; i < nab; i++) begin
            bit_valid = 1'b1; bit_in = 1'($urandom); bit_last = 1'b0;
            @(negedge clk);
         end
         bit_valid = 1'b0;
         @(negedge clk); start = 1'b1;
         @(negedge clk); start = 1'b0;
         @(negedge clk);
         check($sformatf("abort%0d_eng_en", nab), 64'(en_total - en0), 64'(nab / 64));
         rb = {$urandom, $urandom, $urandom, $urandom};
         run_frame(70, rb, 1'b0, crc, lat, nen, stalls);
         check($sformatf("abort%0d_next_crc", nab), 64'(crc), 64'(ref_crc(70, rb)));
      end

      // asynchronous reset in the middle of TAIL
      rb = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int i = 0; i < 104; i++) begin
         bit_valid = 1'b1; bit_in = rb[i]; bit_last = (i == 103);
         @(negedge clk);
      end
      bit_valid = 1'b0; bit_last = 1'b0;
      repeat (3) @(negedge clk);
      check("tail_busy", 64'(busy), 64'd1);
      #1 rst = 1'b1;
      #1;
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_crc_valid", 64'(crc_valid), 64'd0);
      check("arst_crc_out", 64'(crc_out), 64'd0);
      check("arst_eng_data", eng_data, 64'd0);
      check("arst_eng_en", 64'(eng_en), 64'd0);
      @(negedge clk); rst = 1'b0;
      run_frame(104, rb, 1'b0, crc, lat, nen, stalls);
      check("post_rst_crc", 64'(crc), 64'(ref_crc(104, rb)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
